// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display: segment patterns,
// symbol codes, converter states and the symbol-to-segment decoder.
package seg_pkg;

    typedef enum logic [1:0] {
        CV_IDLE  = 2'd0,
        CV_SHIFT = 2'd1,
        CV_DONE  = 2'd2
    } conv_state_e;

    localparam logic [3:0] UNIT_C = 4'd1;
    localparam logic [3:0] UNIT_F = 4'd2;
    localparam logic [3:0] UNIT_H = 4'd3;

    // Internal symbol codes: 0-9 are decimal digits
    localparam logic [3:0] SYM_C     = 4'd10;
    localparam logic [3:0] SYM_F     = 4'd11;
    localparam logic [3:0] SYM_H     = 4'd12;
    localparam logic [3:0] SYM_DASH  = 4'd13;
    localparam logic [3:0] SYM_BLANK = 4'd15;

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] sym);
        logic [6:0] seg;
        case (sym)
            4'd0:     seg = 7'b0000001;
            4'd1:     seg = 7'b1001111;
            4'd2:     seg = 7'b0010010;
            4'd3:     seg = 7'b0000110;
            4'd4:     seg = 7'b1001100;
            4'd5:     seg = 7'b0100100;
            4'd6:     seg = 7'b0100000;
            4'd7:     seg = 7'b0001111;
            4'd8:     seg = 7'b0000000;
            4'd9:     seg = 7'b0000100;
            SYM_C:    seg = 7'b0110001;
            SYM_F:    seg = 7'b0111000;
            SYM_H:    seg = 7'b1001000;
            SYM_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [3:0] unit_to_sym(input logic [3:0] unit);
        logic [3:0] sym;
        case (unit)
            UNIT_C:  sym = SYM_C;
            UNIT_F:  sym = SYM_F;
            UNIT_H:  sym = SYM_H;
            default: sym = SYM_BLANK;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one shift per cycle, result
// held and flagged for one cycle in CV_DONE, where a new start is also accepted.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VAL_W   = 10,
    parameter int NUM_NUM = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [VAL_W-1:0]     i_bin,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [NUM_NUM*4-1:0] o_bcd
);
    localparam int DW    = NUM_NUM * 4;
    localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    conv_state_e      state_q, state_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [DW-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    adj_s;

    // Add-3 correction applied to every nibble before it is shifted.
    always_comb begin
        adj_s = bcd_q;
        for (int n = 0; n < NUM_NUM; n++) begin
            if (bcd_q[n*4 +: 4] > 4'd4) begin
                adj_s[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end else begin
                adj_s[n*4 +: 4] = bcd_q[n*4 +: 4];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            CV_IDLE, CV_DONE: begin
                if (i_start) begin
                    bin_d   = i_bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CV_SHIFT;
                end else begin
                    state_d = CV_IDLE;
                end
            end
            CV_SHIFT: begin
                {bcd_d, bin_d} = {adj_s, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = CV_DONE;
                end else begin
                    state_d = CV_SHIFT;
                end
            end
            default: state_d = CV_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CV_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready = (state_q != CV_SHIFT);
    assign o_done  = (state_q == CV_DONE);
    assign o_bcd   = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multi-channel measurement display: captures channel values, converts them to BCD
// with one shared converter under round-robin arbitration, and scans the digits.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int NUM_NUM  = 3,
    parameter int VAL_W    = 10,
    parameter int REFRESH  = 288000,
    parameter int BLANK_LZ = 1,
    localparam int ND      = NUM_CH * (NUM_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*VAL_W-1:0] i_val,
    input  logic [NUM_CH*4-1:0]     i_unit,
    input  logic [NUM_CH-1:0]       i_load,
    output logic                    o_busy,
    output logic [ND-1:0]           o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp
);
    localparam int DW     = NUM_NUM * 4;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_W  = $clog2(NUM_NUM + 1);
    localparam int SLOT_W = (ND > 1) ? $clog2(ND) : 1;
    localparam int CNT_W  = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [31:0] MAX_V = 32'(10**NUM_NUM - 1);

    logic [NUM_CH-1:0][VAL_W-1:0] val_q, val_d;
    logic [NUM_CH-1:0][3:0]       unit_q, unit_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d, pending_q, pending_d;
    logic [CH_W-1:0]              last_q, last_d, cur_ch_q, cur_ch_d;
    logic                         cur_ovf_q, cur_ovf_d;
    logic [3:0]                   cur_unit_q, cur_unit_d;
    logic [NUM_CH-1:0][DW-1:0]    disp_bcd_q, disp_bcd_d;
    logic [NUM_CH-1:0][3:0]       disp_unit_q, disp_unit_d;
    logic [NUM_CH-1:0]            disp_ovf_q, disp_ovf_d, disp_vld_q, disp_vld_d;
    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic [POS_W-1:0]             pos_q, pos_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ND-1:0]                an_q, an_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         dp_q, dp_d, busy_q, busy_d;

    logic            start_s, conv_ready_s, conv_done_s;
    logic [CH_W-1:0] sel_s, idx_s;
    logic [DW-1:0]   conv_bcd_s;
    logic [3:0]      sym_s, dig_s;
    logic            zero_run_s;
    int              didx_s;

    bin2bcd_seq #(.VAL_W(VAL_W), .NUM_NUM(NUM_NUM)) u_conv (
        .clk    (clk),
        .rst    (rst),
        .i_start(start_s),
        .i_bin  (val_q[sel_s]),
        .o_ready(conv_ready_s),
        .o_done (conv_done_s),
        .o_bcd  (conv_bcd_s)
    );

    // Round-robin pick of the next pending channel after the one served last.
    always_comb begin
        start_s = 1'b0;
        sel_s   = '0;
        idx_s   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s = CH_W'((int'(last_q) + i) % NUM_CH);
            if (!start_s && conv_ready_s && pending_q[idx_s]) begin
                start_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                start_s = start_s;
            end
        end
    end

    // Capture, pending bookkeeping and atomic display register update.
    always_comb begin
        val_d       = val_q;
        unit_d      = unit_q;
        ovf_d       = ovf_q;
        pending_d   = pending_q;
        last_d      = last_q;
        cur_ch_d    = cur_ch_q;
        cur_ovf_d   = cur_ovf_q;
        cur_unit_d  = cur_unit_q;
        disp_bcd_d  = disp_bcd_q;
        disp_unit_d = disp_unit_q;
        disp_ovf_d  = disp_ovf_q;
        disp_vld_d  = disp_vld_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_load[c]) begin
                val_d[c]  = i_val[c*VAL_W +: VAL_W];
                unit_d[c] = i_unit[c*4 +: 4];
                ovf_d[c]  = (32'(i_val[c*VAL_W +: VAL_W]) > MAX_V);
            end else begin
                val_d[c] = val_q[c];
            end
        end
        // Unit and overflow travel with the conversion so a mid-conversion reload
        // cannot pair old digits with new attributes.
        if (start_s) begin
            pending_d[sel_s] = 1'b0;
            last_d           = sel_s;
            cur_ch_d         = sel_s;
            cur_ovf_d        = ovf_q[sel_s];
            cur_unit_d       = unit_q[sel_s];
        end else begin
            last_d = last_q;
        end
        pending_d = pending_d | i_load;
        if (conv_done_s) begin
            disp_bcd_d[cur_ch_q]  = conv_bcd_s;
            disp_unit_d[cur_ch_q] = cur_unit_q;
            disp_ovf_d[cur_ch_q]  = cur_ovf_q;
            disp_vld_d[cur_ch_q]  = 1'b1;
        end else begin
            disp_vld_d = disp_vld_q;
        end
        busy_d = (|pending_d) | start_s | ~conv_ready_s;
    end

    // Scan position: REFRESH cycles per slot, slots counted down with wrap.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        slot_d = slot_q;
        pos_d  = pos_q;
        ch_d   = ch_q;
        if (cnt_q == CNT_W'(REFRESH - 1)) begin
            cnt_d = '0;
            if (slot_q == '0) begin
                slot_d = SLOT_W'(ND - 1);
                pos_d  = POS_W'(NUM_NUM);
                ch_d   = CH_W'(NUM_CH - 1);
            end else if (pos_q == '0) begin
                slot_d = slot_q - SLOT_W'(1);
                pos_d  = POS_W'(NUM_NUM);
                ch_d   = ch_q - CH_W'(1);
            end else begin
                slot_d = slot_q - SLOT_W'(1);
                pos_d  = pos_q - POS_W'(1);
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Symbol selection for the current slot; pos 0 is the unit, pos k>0 is digit k-1.
    always_comb begin
        an_d       = '1;
        dp_d       = 1'b1;
        sym_s      = SYM_BLANK;
        zero_run_s = 1'b1;
        didx_s     = (pos_q == '0) ? 0 : int'(pos_q) - 1;
        dig_s      = disp_bcd_q[ch_q][didx_s*4 +: 4];
        if (cnt_q != '0) begin
            an_d[slot_q] = 1'b0;
        end else begin
            an_d = '1;
        end
        for (int k = 0; k < NUM_NUM; k++) begin
            zero_run_s = zero_run_s & ((k < didx_s) | (disp_bcd_q[ch_q][k*4 +: 4] == 4'd0));
        end
        if (!disp_vld_q[ch_q]) begin
            sym_s = SYM_BLANK;
        end else if (pos_q == '0) begin
            sym_s = unit_to_sym(disp_unit_q[ch_q]);
        end else begin
            dp_d = (didx_s == 1) ? 1'b0 : 1'b1;
            if (disp_ovf_q[ch_q]) begin
                sym_s = SYM_DASH;
            end else if ((BLANK_LZ != 0) && (didx_s >= 2) && zero_run_s) begin
                sym_s = SYM_BLANK;
            end else begin
                sym_s = dig_s;
            end
        end
        seg_d = seg_decode(sym_s);
    end

    // All state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q       <= '0;
            unit_q      <= '0;
            ovf_q       <= '0;
            pending_q   <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            cur_ch_q    <= '0;
            cur_ovf_q   <= 1'b0;
            cur_unit_q  <= 4'd0;
            disp_bcd_q  <= '0;
            disp_unit_q <= '0;
            disp_ovf_q  <= '0;
            disp_vld_q  <= '0;
            slot_q      <= SLOT_W'(ND - 1);
            pos_q       <= POS_W'(NUM_NUM);
            ch_q        <= CH_W'(NUM_CH - 1);
            cnt_q       <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            val_q       <= val_d;
            unit_q      <= unit_d;
            ovf_q       <= ovf_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            cur_ch_q    <= cur_ch_d;
            cur_ovf_q   <= cur_ovf_d;
            cur_unit_q  <= cur_unit_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_unit_q <= disp_unit_d;
            disp_ovf_q  <= disp_ovf_d;
            disp_vld_q  <= disp_vld_d;
            slot_q      <= slot_d;
            pos_q       <= pos_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            busy_q      <= busy_d;
        end
    end

    assign o_an   = an_q;
    assign o_seg  = seg_q;
    assign o_dp   = dp_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with REFRESH=4: scan pattern, conversion
// latency, blanking, overflow, arbitration, reload during conversion and reset abort.
module tb_seg_scan_display;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100, SC = 7'b0110001, SF = 7'b0111000;
    localparam logic [6:0] SH = 7'b1001000, SD = 7'b1111110, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] i_val = 20'd0;
    logic [7:0]  i_unit = 8'd0;
    logic [1:0]  i_load = 2'b00;
    logic        o_busy, o_dp;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int             ch;
        logic [9:0]     val;
        logic [3:0]     unit;
        logic [3:0][6:0] segs;
        logic [3:0]     dps;
    } vec_t;
    vec_t vecs[8];

    seg_scan_display #(.REFRESH(4)) dut (
        .clk(clk), .rst(rst), .i_val(i_val), .i_unit(i_unit), .i_load(i_load),
        .o_busy(o_busy), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge; the load is captured on the next posedge.
    task automatic load(input logic [1:0] ld, input logic [19:0] v, input logic [7:0] u);
        i_load = ld;
        i_val  = v;
        i_unit = u;
        @(negedge clk);
        i_load = 2'b00;
    endtask

    task automatic check_slot(input int s, input logic [6:0] es, input logic edp, input int tag);
        logic [7:0] tgt;
        bit found;
        tgt   = 8'hFF;
        tgt[s] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (o_an === tgt) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL slot_wait tag %0d slot %0d: anode never selected", tag, s);
        end else begin
            chk($sformatf("slot_seg tag %0d slot %0d", tag, s), {24'd0, o_dp, o_seg}, {24'd0, edp, es});
        end
    endtask

    task automatic check_busy_drop(input int drop_at, input int already, input int tag);
        for (int k = already + 1; k <= drop_at; k++) begin
            @(negedge clk);
            if (k == drop_at - 1) chk($sformatf("busy_high tag %0d", tag), {31'd0, o_busy}, 32'd1);
            if (k == drop_at)     chk($sformatf("busy_low tag %0d", tag), {31'd0, o_busy}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 10'd725,  4'd2, {S7, S2, S5, SF}, 4'b1011};
        vecs[1] = '{1, 10'd5,    4'd3, {SB, S0, S5, SH}, 4'b1011};
        vecs[2] = '{0, 10'd1000, 4'd1, {SD, SD, SD, SC}, 4'b1011};
        vecs[3] = '{1, 10'd40,   4'd0, {SB, S4, S0, SB}, 4'b1011};
        vecs[4] = '{0, 10'd999,  4'd7, {S9, S9, S9, SB}, 4'b1011};
        vecs[5] = '{1, 10'd0,    4'd1, {SB, S0, S0, SC}, 4'b1011};
        vecs[6] = '{0, 10'd100,  4'd3, {S1, S0, S0, SH}, 4'b1011};
        vecs[7] = '{1, 10'd1023, 4'd2, {SD, SD, SD, SF}, 4'b1011};

        repeat (3) @(negedge clk);
        chk("rst_an",   {24'd0, o_an}, 32'hFF);
        chk("rst_seg",  {25'd0, o_seg}, {25'd0, SB});
        chk("rst_dp",   {31'd0, o_dp}, 32'd1);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;

        // Blank scan: one all-high cycle then three cycles per slot, slot 7 first.
        for (int k = 1; k <= 32; k++) begin
            logic [7:0] exp_an;
            @(negedge clk);
            exp_an = 8'hFF;
            if (((k - 1) % 4) != 0) exp_an[7 - (k - 1) / 4] = 1'b0;
            chk($sformatf("scan_an k%0d", k), {24'd0, o_an}, {24'd0, exp_an});
            chk($sformatf("scan_seg k%0d", k), {24'd0, o_dp, o_seg}, {24'd0, 1'b1, SB});
        end

        for (int v = 0; v < 8; v++) begin
            logic [19:0] vv;
            logic [7:0]  uu;
            logic [1:0]  ll;
            vv = 20'd0; uu = 8'd0; ll = 2'b00;
            vv[vecs[v].ch*10 +: 10] = vecs[v].val;
            uu[vecs[v].ch*4 +: 4]   = vecs[v].unit;
            ll[vecs[v].ch]          = 1'b1;
            load(ll, vv, uu);
            check_busy_drop(12, 0, v);
            for (int p = 3; p >= 0; p--) begin
                check_slot(vecs[v].ch*4 + p, vecs[v].segs[p], vecs[v].dps[p], v);
            end
        end

        // Simultaneous loads: ch0 first, ch1 finishes VAL_W+1 cycles after it.
        load(2'b11, {10'd654, 10'd321}, {4'd2, 4'd1});
        check_busy_drop(23, 0, 100);
        check_slot(7, S6, 1'b1, 101); check_slot(6, S5, 1'b0, 101);
        check_slot(5, S4, 1'b1, 101); check_slot(4, SF, 1'b1, 101);
        check_slot(3, S3, 1'b1, 102); check_slot(2, S2, 1'b0, 102);
        check_slot(1, S1, 1'b1, 102); check_slot(0, SC, 1'b1, 102);

        // Reload of ch0 while ch0 converts: reconverted afterwards with the new value.
        load(2'b01, 20'd111, 8'h03);
        repeat (2) @(negedge clk);
        load(2'b01, 20'd222, 8'h02);
        check_busy_drop(23, 3, 103);
        check_slot(3, S2, 1'b1, 104); check_slot(2, S2, 1'b0, 104);
        check_slot(1, S2, 1'b1, 104); check_slot(0, SF, 1'b1, 104);

        // Reset five cycles into a conversion aborts it; displays stay blank.
        load(2'b10, {10'd888, 10'd0}, 8'h10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_an",   {24'd0, o_an}, 32'hFF);
        chk("abort_seg",  {24'd0, o_dp, o_seg}, {24'd0, 1'b1, SB});
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_busy_after", {31'd0, o_busy}, 32'd0);
        for (int s = 7; s >= 0; s--) check_slot(s, SB, 1'b1, 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
